// File: rtl/xoodyak_pkg.sv
// Shared types and constants for the single-block Xoodyak decrypt engine.
// A 384-bit state vector holds byte 0 in [383:376]; each lane is little-endian.
package xoodyak_pkg;

    localparam int NROUNDS = 12;
    localparam int MSG_W   = 192;
    localparam int TAG_W   = 128;
    localparam int STATE_W = 384;

    localparam logic [7:0] CU_CRYPT   = 8'h80;
    localparam logic [7:0] CU_SQUEEZE = 8'h40;
    localparam logic [7:0] PAD_01     = 8'h01;

    localparam logic [31:0] RC [0:NROUNDS-1] = '{
        32'h058, 32'h038, 32'h3C0, 32'h0D0, 32'h120, 32'h014,
        32'h060, 32'h02C, 32'h380, 32'h0F0, 32'h1A0, 32'h012
    };

    typedef enum logic [2:0] {IDLE, UP1, DOWN, UP2, DONE} dec_state_e;

    // [plane y][lane x][bit z]
    typedef logic [2:0][3:0][31:0] planes_t;

    function automatic planes_t to_planes(input logic [STATE_W-1:0] s);
        planes_t p;
        p = '0;
        for (int y = 0; y < 3; y++)
            for (int x = 0; x < 4; x++)
                for (int b = 0; b < 4; b++)
                    p[y][x][8*b +: 8] = s[STATE_W-1 - 8*(16*y + 4*x + b) -: 8];
        return p;
    endfunction

    function automatic logic [STATE_W-1:0] from_planes(input planes_t p);
        logic [STATE_W-1:0] s;
        s = '0;
        for (int y = 0; y < 3; y++)
            for (int x = 0; x < 4; x++)
                for (int b = 0; b < 4; b++)
                    s[STATE_W-1 - 8*(16*y + 4*x + b) -: 8] = p[y][x][8*b +: 8];
        return s;
    endfunction

endpackage

// File: rtl/xoodyak_decrypt_round.sv
// One combinational Xoodoo round: theta, rho-west, iota, chi, rho-east.
module xoodoo_round
    import xoodyak_pkg::*;
(
    input  logic [STATE_W-1:0] state_i,
    input  logic [31:0]        rc_i,
    output logic [STATE_W-1:0] state_o
);

    function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
        return (v << n) | (v >> (32 - n));
    endfunction

    planes_t          a, b, c, d;
    logic [3:0][31:0] par, eff;

    always_comb begin
        a   = to_planes(state_i);
        par = '0;
        eff = '0;
        for (int x = 0; x < 4; x++)
            par[x] = a[0][x] ^ a[1][x] ^ a[2][x];
        for (int x = 0; x < 4; x++)
            eff[x] = rotl(par[(x+3)%4], 5) ^ rotl(par[(x+3)%4], 14);
        for (int y = 0; y < 3; y++)
            for (int x = 0; x < 4; x++)
                a[y][x] = a[y][x] ^ eff[x];

        b = a;
        for (int x = 0; x < 4; x++) begin
            b[1][x] = a[1][(x+3)%4];
            b[2][x] = rotl(a[2][x], 11);
        end
        b[0][0] = b[0][0] ^ rc_i;

        c = b;
        for (int y = 0; y < 3; y++)
            for (int x = 0; x < 4; x++)
                c[y][x] = b[y][x] ^ (~b[(y+1)%3][x] & b[(y+2)%3][x]);

        d = c;
        for (int x = 0; x < 4; x++) begin
            d[1][x] = rotl(c[1][x], 1);
            d[2][x] = rotl(c[2][(x+2)%4], 8);
        end

        state_o = from_planes(d);
    end

endmodule

// File: rtl/xoodyak_decrypt.sv
// Single-block Xoodyak decrypt: Up(0x80), Down(P), Up(0x40), tag compare.
// Define XOOD_DEC_ZEROIZE_EN to withhold plaintext/state_out on tag mismatch.
//   state | meaning
//   IDLE  | wait for start, load state_in ^ 0x80
//   UP1   | 12 rounds producing the keystream
//   DOWN  | recover P, absorb P|0x01 and 0x40
//   UP2   | 12 rounds producing the tag, compare on the last one
//   DONE  | one-cycle done pulse
module xoodyak_decrypt
    import xoodyak_pkg::*;
(
    input  logic               eph1_i,
    input  logic               reset_i,
    input  logic               start_i,
    input  logic [STATE_W-1:0] state_in_i,
    input  logic [MSG_W-1:0]   ciphertext_i,
    input  logic [TAG_W-1:0]   tag_in_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [MSG_W-1:0]   plaintext_o,
    output logic               tag_ok_o,
    output logic [STATE_W-1:0] state_out_o
);

    dec_state_e         fsm_q;
    logic [3:0]         rnd_q;
    logic [STATE_W-1:0] st_q, so_q, round_d;
    logic [MSG_W-1:0]   pt_q, p_d;
    logic               busy_q, done_q, tag_ok_q;
    logic               last_rnd_d, tag_match_d;
`ifdef XOOD_DEC_ZEROIZE_EN
    logic [MSG_W-1:0]   hold_q;
`endif

    xoodoo_round u_round (
        .state_i (st_q),
        .rc_i    (RC[rnd_q]),
        .state_o (round_d)
    );

    assign last_rnd_d  = (rnd_q == 4'(NROUNDS - 1));
    assign p_d         = ciphertext_i ^ st_q[STATE_W-1 -: MSG_W];
    assign tag_match_d = (round_d[STATE_W-1 -: TAG_W] == tag_in_i);

    always_ff @(posedge eph1_i) begin
        if (reset_i) begin
            fsm_q    <= IDLE;
            rnd_q    <= '0;
            st_q     <= '0;
            so_q     <= '0;
            pt_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            tag_ok_q <= 1'b0;
`ifdef XOOD_DEC_ZEROIZE_EN
            hold_q   <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (fsm_q)
                IDLE: begin
                    if (start_i) begin
                        st_q   <= state_in_i ^ {{(STATE_W-8){1'b0}}, CU_CRYPT};
                        rnd_q  <= '0;
                        busy_q <= 1'b1;
                        fsm_q  <= UP1;
                    end
                end
                UP1: begin
                    st_q <= round_d;
                    if (last_rnd_d) begin
                        rnd_q <= '0;
                        fsm_q <= DOWN;
                    end else begin
                        rnd_q <= rnd_q + 4'd1;
                    end
                end
                DOWN: begin
`ifdef XOOD_DEC_ZEROIZE_EN
                    hold_q <= p_d;
`else
                    pt_q   <= p_d;
`endif
                    st_q  <= st_q ^ {p_d, PAD_01, {(STATE_W-MSG_W-8){1'b0}}}
                                  ^ {{(STATE_W-8){1'b0}}, CU_SQUEEZE};
                    fsm_q <= UP2;
                end
                UP2: begin
                    st_q <= round_d;
                    if (last_rnd_d) begin
                        rnd_q    <= '0;
                        tag_ok_q <= tag_match_d;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        fsm_q    <= DONE;
`ifdef XOOD_DEC_ZEROIZE_EN
                        // Plaintext and chaining state leave only after the tag verifies.
                        if (tag_match_d) begin
                            pt_q <= hold_q;
                            so_q <= round_d;
                        end else begin
                            pt_q   <= '0;
                            so_q   <= '0;
                            hold_q <= '0;
                        end
`else
                        so_q <= round_d;
`endif
                    end else begin
                        rnd_q <= rnd_q + 4'd1;
                    end
                end
                DONE:    fsm_q <= IDLE;
                default: fsm_q <= IDLE;
            endcase
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign plaintext_o = pt_q;
    assign tag_ok_o    = tag_ok_q;
    assign state_out_o = so_q;

endmodule
